hazard_forward_unit: RTL and testbench
======================================

HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 Parameter: ADDR_W, default 3, register-address width (8 architectural registers).
REQ-002 Parameter: R0_HARDWIRED, default 0; 1 = register 0 is never a forwarding or stall source.
REQ-003 Port list, in order:
  - clk  input  1  single clock; all state on rising edge.
  - reset  input  1  asynchronous, active-high.
  - id_valid  input  1  decode stage holds a real instruction.
  - id_rs1, id_rs2  input  ADDR_W  decode-stage source registers.
  - id_use_rs1, id_use_rs2  input  1  corresponding source is actually read.
  - id_rd  input  ADDR_W  decode-stage destination register.
  - id_reg_write  input  1  decode instruction writes id_rd.
  - id_mem_read  input  1  decode instruction is a load.
  - flush  input  1  branch/jump flush of ID and EX.
  - forward_a, forward_b  output  2  select codes for the EX-stage operand muxes: 00 = register-file value, 01 = ALU_Result (EX/MEM), 10 = Result (MEM/WB), 11 = unused.
  - stall  output  1  hold PC and IF/ID this cycle.
  - ex_bubble  output  1  EX stage holds an inserted bubble.
  - stall_count  output  8  saturating count of load-use stalls.

Function
REQ-004 The block SHALL keep a shadow pipeline: EX slot {valid, rs1, rs2, use1, use2, rd, reg_write, mem_read}, MEM slot {valid, rd, reg_write, mem_read}, WB slot {valid, rd, reg_write}.
REQ-005 Every cycle: MEM <= EX, and WB <= MEM.
REQ-006 Every cycle the EX slot SHALL load the ID inputs, except that it loads a bubble (valid=0, all other fields 0) when stall or flush is asserted.
REQ-007 forward_a SHALL be 01 when the EX slot uses rs1, the MEM slot is valid with reg_write=1 and mem_read=0, and MEM.rd == EX.rs1.
REQ-008 Otherwise forward_a SHALL be 10 when the WB slot is valid with reg_write=1 and WB.rd == EX.rs1.
REQ-009 Otherwise forward_a SHALL be 00; forward_b follows the same rules using rs2.
REQ-010 A MEM-slot match SHALL take priority over a WB-slot match on the same register.
REQ-011 With R0_HARDWIRED=1, a source or destination equal to 0 SHALL never match.
REQ-012 forward_a and forward_b SHALL be combinational from slot registers only; they SHALL be 00 when the EX slot is not valid.
REQ-013 State machine RUN/STALL, state register.
REQ-014 The load-use condition is: id_valid, EX valid with mem_read=1 and reg_write=1, and EX.rd matches an id_rs used by the decode instruction.
REQ-015 In RUN, stall SHALL assert combinationally on the load-use condition, and the state SHALL go to STALL.
REQ-016 In STALL, stall SHALL be 0 (the load is now in MEM, so a bubble has been inserted), and the state SHALL return to RUN.
REQ-017 Latency: exactly one stall cycle per load-use hazard; the consumer enters EX with forward code 10 against the load.
REQ-018 When flush and the load-use condition are both present, flush SHALL win: stall=0, the EX bubble is inserted, the state stays RUN, and stall_count does not increment.
REQ-019 stall_count SHALL increment on each cycle where stall=1 and saturate at 8'hFF.
REQ-020 ex_bubble SHALL be registered: it is 1 in the cycle after a bubble is loaded into EX.

Reset
REQ-021 While reset is high, all slots SHALL be invalid and the state SHALL be RUN.
REQ-022 Reset values: forward_a=00, forward_b=00, stall=0, ex_bubble=0, stall_count=0.
REQ-023 Reset asserted mid-stall SHALL abort the stall immediately, with no increment.

Verification
REQ-024 Back-to-back ALU ops r1=..., then add r2,r1,r3 -> forward_a=01 in the consumer's EX cycle; forward_b=00.
REQ-025 Producer to r4, one independent op, then consumer reads r4 on rs2 -> forward_b=10.
REQ-026 Two writers to r5 in consecutive slots, then a reader of r5 -> forward code 01 (youngest wins).
REQ-027 Load r6, then immediate reader of r6 -> stall=1 for one cycle, ex_bubble=1 next cycle, then forward=10 and stall_count=1.
REQ-028 Load-use hazard with flush=1 in the same cycle -> stall=0, stall_count unchanged.
REQ-029 Reset asserted during a STALL cycle -> all outputs zero; 256 stalls -> stall_count holds 8'hFF.

Source files
------------

// File: rtl/hazard_forward_unit.sv
// Hazard detection and operand forwarding for a 5-stage in-order pipeline.
// Tracks a shadow EX/MEM/WB copy of register usage to drive forward/stall.
module hazard_forward_unit #(
    parameter int ADDR_W       = 3,
    parameter bit R0_HARDWIRED = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rs1,
    input  logic [ADDR_W-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [ADDR_W-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              flush,
    output logic [1:0]        forward_a,
    output logic [1:0]        forward_b,
    output logic              stall,
    output logic              ex_bubble,
    output logic [7:0]        stall_count
);

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] rs1;
        logic [ADDR_W-1:0] rs2;
        logic              use1;
        logic              use2;
        logic [ADDR_W-1:0] rd;
        logic              reg_write;
        logic              mem_read;
    } ex_slot_t;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] rd;
        logic              reg_write;
        logic              mem_read;
    } mem_slot_t;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] rd;
        logic              reg_write;
    } wb_slot_t;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t    state;
    state_t    state_next;
    ex_slot_t  ex_q;
    ex_slot_t  ex_next;
    mem_slot_t mem_q;
    wb_slot_t  wb_q;
    logic      load_use;
    logic      insert_bubble;

    // Register 0 optionally never participates in a dependency.
    function automatic logic reg_match(
        input logic [ADDR_W-1:0] a,
        input logic [ADDR_W-1:0] b
    );
        return (a == b) && !(R0_HARDWIRED && (a == '0));
    endfunction

    // Operand select for one EX source; younger MEM result beats WB.
    function automatic logic [1:0] fwd_sel(
        input logic              src_used,
        input logic [ADDR_W-1:0] src
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (ex_q.valid) begin
            if (src_used && mem_q.valid && mem_q.reg_write &&
                !mem_q.mem_read && reg_match(mem_q.rd, src)) begin
                sel = FWD_MEM;
            end else if (wb_q.valid && wb_q.reg_write &&
                         reg_match(wb_q.rd, src)) begin
                sel = FWD_WB;
            end
        end
        return sel;
    endfunction

    // Forward codes depend only on the shadow slot registers.
    always_comb begin
        forward_a = fwd_sel(ex_q.use1, ex_q.rs1);
        forward_b = fwd_sel(ex_q.use2, ex_q.rs2);
    end

    // Decode instruction needs a value a load in EX has not produced yet.
    always_comb begin
        load_use = id_valid && ex_q.valid &&
                   ex_q.mem_read && ex_q.reg_write &&
                   ((id_use_rs1 && reg_match(ex_q.rd, id_rs1)) ||
                    (id_use_rs2 && reg_match(ex_q.rd, id_rs2)));
    end

    // RUN/STALL next state and stall output; flush overrides a stall.
    always_comb begin
        state_next = state;
        stall      = 1'b0;
        unique case (state)
            RUN: begin
                if (load_use && !flush) begin
                    stall      = 1'b1;
                    state_next = STALL;
                end
            end
            STALL: begin
                state_next = RUN;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // EX slot takes the decode instruction unless a bubble is inserted.
    always_comb begin
        insert_bubble = stall || flush;
        ex_next       = '0;
        if (!insert_bubble) begin
            ex_next.valid     = id_valid;
            ex_next.rs1       = id_rs1;
            ex_next.rs2       = id_rs2;
            ex_next.use1      = id_use_rs1;
            ex_next.use2      = id_use_rs2;
            ex_next.rd        = id_rd;
            ex_next.reg_write = id_reg_write;
            ex_next.mem_read  = id_mem_read;
        end
    end

    // Advance the shadow pipeline, FSM, bubble flag and stall counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            ex_bubble   <= 1'b0;
            stall_count <= 8'h00;
        end else begin
            state           <= state_next;
            ex_q            <= ex_next;
            mem_q.valid     <= ex_q.valid;
            mem_q.rd        <= ex_q.rd;
            mem_q.reg_write <= ex_q.reg_write;
            mem_q.mem_read  <= ex_q.mem_read;
            wb_q.valid      <= mem_q.valid;
            wb_q.rd         <= mem_q.rd;
            wb_q.reg_write  <= mem_q.reg_write;
            ex_bubble       <= insert_bubble;
            if (stall && (stall_count != 8'hFF)) begin
                stall_count <= stall_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: forwarding, load-use stall,
// flush priority, reset mid-stall and counter saturation.
module tb_hazard_forward_unit;

    logic       clk;
    logic       reset;
    logic       id_valid;
    logic [2:0] id_rs1;
    logic [2:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic [2:0] id_rd;
    logic       id_reg_write;
    logic       id_mem_read;
    logic       flush;

    logic [1:0] forward_a;
    logic [1:0] forward_b;
    logic       stall;
    logic       ex_bubble;
    logic [7:0] stall_count;

    logic [1:0] h_forward_a;
    logic [1:0] h_forward_b;
    logic       h_stall;
    logic       h_ex_bubble;
    logic [7:0] h_stall_count;

    typedef struct {
        string       tag;
        logic [13:0] v;
        bit          hard;
    } exp_t;

    exp_t q[$];
    int   checks;
    int   errors;

    hazard_forward_unit #(.ADDR_W(3), .R0_HARDWIRED(1'b0)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .flush(flush),
        .forward_a(forward_a), .forward_b(forward_b),
        .stall(stall), .ex_bubble(ex_bubble),
        .stall_count(stall_count)
    );

    hazard_forward_unit #(.ADDR_W(3), .R0_HARDWIRED(1'b1)) dut_h (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .flush(flush),
        .forward_a(h_forward_a), .forward_b(h_forward_b),
        .stall(h_stall), .ex_bubble(h_ex_bubble),
        .stall_count(h_stall_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic drive(
        input logic       v,
        input logic [2:0] rs1,
        input logic [2:0] rs2,
        input logic       u1,
        input logic       u2,
        input logic [2:0] rd,
        input logic       rw,
        input logic       mr,
        input logic       fl
    );
        id_valid     = v;
        id_rs1       = rs1;
        id_rs2       = rs2;
        id_use_rs1   = u1;
        id_use_rs2   = u2;
        id_rd        = rd;
        id_reg_write = rw;
        id_mem_read  = mr;
        flush        = fl;
    endtask

    task automatic nop();
        drive(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic alu(
        input logic [2:0] rd,
        input logic [2:0] rs1,
        input logic [2:0] rs2,
        input logic       u1,
        input logic       u2
    );
        drive(1'b1, rs1, rs2, u1, u2, rd, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic ld(input logic [2:0] rd);
        drive(1'b1, 3'd0, 3'd0, 1'b1, 1'b0, rd, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic push(
        input string      tag,
        input logic [1:0] fa,
        input logic [1:0] fb,
        input logic       st,
        input logic       bub,
        input logic [7:0] cnt,
        input bit         hard
    );
        exp_t e;
        e.tag  = tag;
        e.v    = {fa, fb, st, bub, cnt};
        e.hard = hard;
        q.push_back(e);
    endtask

    task automatic compare_front();
        exp_t        e;
        logic [13:0] got;
        e = q.pop_front();
        if (e.hard) begin
            got = {h_forward_a, h_forward_b, h_stall,
                   h_ex_bubble, h_stall_count};
        end else begin
            got = {forward_a, forward_b, stall,
                   ex_bubble, stall_count};
        end
        checks++;
        assert (got === e.v) else begin
            errors++;
            $error("FAIL %s: observed fa=%b fb=%b st=%b bub=%b cnt=%h expected fa=%b fb=%b st=%b bub=%b cnt=%h",
                   e.tag, got[13:12], got[11:10], got[9], got[8],
                   got[7:0], e.v[13:12], e.v[11:10], e.v[9],
                   e.v[8], e.v[7:0]);
        end
    endtask

    task automatic chk(
        input string      tag,
        input logic [1:0] fa,
        input logic [1:0] fb,
        input logic       st,
        input logic       bub,
        input logic [7:0] cnt
    );
        push(tag, fa, fb, st, bub, cnt, 1'b0);
        #1;
        compare_front();
    endtask

    task automatic cyc(
        input string      tag,
        input logic [1:0] fa,
        input logic [1:0] fb,
        input logic       st,
        input logic       bub,
        input logic [7:0] cnt
    );
        chk(tag, fa, fb, st, bub, cnt);
        @(negedge clk);
    endtask

    task automatic load_use_round();
        ld(3'd6);
        @(negedge clk);
        alu(3'd2, 3'd6, 3'd0, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        nop();
        @(negedge clk);
        cyc("reset_state", 2'b00, 2'b00, 1'b0, 1'b0, 8'h00);
        reset = 1'b0;

        alu(3'd1, 3'd0, 3'd0, 1'b0, 1'b0);
        cyc("prod_r1", 2'b00, 2'b00, 1'b0, 1'b0, 8'h00);
        alu(3'd2, 3'd1, 3'd3, 1'b1, 1'b1);
        cyc("cons_r1_id", 2'b00, 2'b00, 1'b0, 1'b0, 8'h00);
        nop();
        cyc("fwd_mem_a", 2'b01, 2'b00, 1'b0, 1'b0, 8'h00);

        alu(3'd4, 3'd0, 3'd0, 1'b0, 1'b0);
        cyc("prod_r4", 2'b00, 2'b00, 1'b0, 1'b0, 8'h00);
        alu(3'd7, 3'd0, 3'd0, 1'b0, 1'b0);
        cyc("indep", 2'b00, 2'b00, 1'b0, 1'b0, 8'h00);
        alu(3'd3, 3'd0, 3'd4, 1'b0, 1'b1);
        cyc("cons_r4_id", 2'b00, 2'b00, 1'b0, 1'b0, 8'h00);
        nop();
        cyc("fwd_wb_b", 2'b00, 2'b10, 1'b0, 1'b0, 8'h00);

        alu(3'd5, 3'd0, 3'd0, 1'b0, 1'b0);
        cyc("w5_old", 2'b00, 2'b00, 1'b0, 1'b0, 8'h00);
        alu(3'd5, 3'd0, 3'd0, 1'b0, 1'b0);
        cyc("w5_young", 2'b00, 2'b00, 1'b0, 1'b0, 8'h00);
        alu(3'd3, 3'd5, 3'd5, 1'b1, 1'b1);
        cyc("r5_id", 2'b00, 2'b00, 1'b0, 1'b0, 8'h00);
        nop();
        cyc("youngest_wins", 2'b01, 2'b01, 1'b0, 1'b0, 8'h00);

        ld(3'd6);
        cyc("load_r6", 2'b00, 2'b00, 1'b0, 1'b0, 8'h00);
        alu(3'd2, 3'd6, 3'd0, 1'b1, 1'b0);
        cyc("load_use_stall", 2'b00, 2'b00, 1'b1, 1'b0, 8'h00);
        cyc("stall_bubble", 2'b00, 2'b00, 1'b0, 1'b1, 8'h01);
        nop();
        cyc("fwd_after_load", 2'b10, 2'b00, 1'b0, 1'b0, 8'h01);

        ld(3'd6);
        cyc("load_r6_again", 2'b00, 2'b00, 1'b0, 1'b0, 8'h01);
        drive(1'b1, 3'd6, 3'd0, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0, 1'b1);
        cyc("flush_wins", 2'b00, 2'b00, 1'b0, 1'b0, 8'h01);
        nop();
        cyc("flush_bubble", 2'b00, 2'b00, 1'b0, 1'b1, 8'h01);

        alu(3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
        cyc("prod_r0", 2'b00, 2'b00, 1'b0, 1'b0, 8'h01);
        alu(3'd3, 3'd0, 3'd0, 1'b1, 1'b0);
        cyc("cons_r0_id", 2'b00, 2'b00, 1'b0, 1'b0, 8'h01);
        nop();
        push("r0_hardwired", 2'b00, 2'b00, 1'b0, 1'b0, 8'h01, 1'b1);
        chk("r0_soft", 2'b01, 2'b00, 1'b0, 1'b0, 8'h01);
        compare_front();
        @(negedge clk);
        cyc("ex_invalid_no_fwd", 2'b00, 2'b00, 1'b0, 1'b0, 8'h01);

        ld(3'd6);
        cyc("load_pre_reset", 2'b00, 2'b00, 1'b0, 1'b0, 8'h01);
        alu(3'd2, 3'd6, 3'd0, 1'b1, 1'b0);
        chk("stall_pre_reset", 2'b00, 2'b00, 1'b1, 1'b0, 8'h01);
        reset = 1'b1;
        chk("reset_mid_stall", 2'b00, 2'b00, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        chk("reset_held", 2'b00, 2'b00, 1'b0, 1'b0, 8'h00);
        nop();
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 255; i++) begin
            load_use_round();
        end
        nop();
        @(negedge clk);
        cyc("count_255", 2'b00, 2'b00, 1'b0, 1'b0, 8'hFF);
        for (int i = 0; i < 5; i++) begin
            load_use_round();
        end
        nop();
        @(negedge clk);
        cyc("count_saturated", 2'b00, 2'b00, 1'b0, 1'b0, 8'hFF);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
